// File: rtl/alu_bist_pkg.sv
// Shared definitions for the ALU built-in self-test: opcodes, FSM encoding,
// LFSR taps and the record carried down the compare pipeline.
package alu_bist_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b1001;
    localparam logic [3:0] OP_XOR = 4'b1010;
    localparam logic [3:0] OP_NOT = 4'b1011;
    localparam logic [3:0] OP_SHR = 4'b1100;
    localparam logic [3:0] OP_SHL = 4'b1101;
    localparam logic [3:0] OP_ROR = 4'b1110;
    localparam logic [3:0] OP_ROL = 4'b1111;

    // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form: taps at bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef struct packed {
        logic       v;
        logic [7:0] expv;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] ctr;
    } vec_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/alu_bist_ref.sv
// Golden combinational ALU: the result the unit under test must return for a vector.
module alu_ref
    import alu_bist_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] ctr,
    output logic [7:0] y
);

    always_comb begin
        y = 8'h00;
        case (ctr)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOT:  y = ~a;
            OP_SHR:  y = {1'b0, a[7:1]};
            OP_SHL:  y = {a[6:0], 1'b0};
            OP_ROR:  y = {a[0], a[7:1]};
            OP_ROL:  y = {a[6:0], a[7]};
            default: y = 8'h00;
        endcase
    end

endmodule

// File: rtl/alu_bist.sv
// LFSR-driven self-test for an 8-bit ALU: issues n_ops vectors, checks each
// result LAT edges later, and reports error count plus the first failing vector.
module alu_bist #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter int          LAT  = 2
) (
    input  logic        ck,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] n_ops,
    output logic [7:0]  a,
    output logic [7:0]  b,
    output logic [3:0]  ctr,
    input  logic [7:0]  alu_o,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_cnt,
    output logic [7:0]  fail_a,
    output logic [7:0]  fail_b,
    output logic [3:0]  fail_ctr,
    output logic [7:0]  fail_o,
    output logic [1:0]  dbg_state
);
    import alu_bist_pkg::*;

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    state_t      state, state_n;
    logic        launch, issue;
    logic [15:0] lfsr, issue_cnt, drain_cnt;
    logic        v_iss;
    logic [7:0]  exp_now;
    vec_t        pipe [LAT];
    vec_t        tail;
    logic        hit, seen_q;
    logic [7:0]  err_q, fail_a_q, fail_b_q, fail_o_q;
    logic [3:0]  fail_ctr_q;

    alu_ref u_ref (.a(a), .b(b), .ctr(ctr), .y(exp_now));

    always_ff @(posedge ck or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        launch  = 1'b0;
        issue   = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    launch  = 1'b1;
                    state_n = (n_ops == 16'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                issue = 1'b1;
                if (issue_cnt <= 16'd1) state_n = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_cnt == 16'd0) state_n = S_DONE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            lfsr       <= SEED_EFF;
            issue_cnt  <= 16'd0;
            drain_cnt  <= 16'd0;
            a          <= 8'h00;
            b          <= 8'h00;
            ctr        <= 4'h0;
            v_iss      <= 1'b0;
            seen_q     <= 1'b0;
            err_q      <= 8'h00;
            fail_a_q   <= 8'h00;
            fail_b_q   <= 8'h00;
            fail_ctr_q <= 4'h0;
            fail_o_q   <= 8'h00;
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            v_iss        <= issue;
            // a/b/ctr hold the vector issued last edge, so its expected value enters here.
            pipe[0].v    <= v_iss;
            pipe[0].expv <= exp_now;
            pipe[0].a    <= a;
            pipe[0].b    <= b;
            pipe[0].ctr  <= ctr;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];

            if (launch) begin
                lfsr       <= SEED_EFF;
                issue_cnt  <= n_ops;
                seen_q     <= 1'b0;
                err_q      <= 8'h00;
                fail_a_q   <= 8'h00;
                fail_b_q   <= 8'h00;
                fail_ctr_q <= 4'h0;
                fail_o_q   <= 8'h00;
                for (int i = 0; i < LAT; i++) pipe[i].v <= 1'b0;
            end else begin
                seen_q     <= seen_q | hit;
                err_q      <= err_cnt;
                fail_a_q   <= fail_a;
                fail_b_q   <= fail_b;
                fail_ctr_q <= fail_ctr;
                fail_o_q   <= fail_o;
            end

            if (issue) begin
                a         <= lfsr[7:0];
                b         <= lfsr[15:8];
                ctr       <= lfsr[11:8] ^ lfsr[3:0];
                lfsr      <= lfsr_step(lfsr);
                issue_cnt <= issue_cnt - 16'd1;
                drain_cnt <= 16'(LAT - 1);
            end else if (state == S_DRAIN && drain_cnt != 16'd0) begin
                drain_cnt <= drain_cnt - 16'd1;
            end
        end
    end

    // Reported counters fold in the comparison being made this cycle, so the
    // last vector's verdict is already visible in the first DONE cycle.
    always_comb begin
        tail     = pipe[LAT-1];
        hit      = tail.v && (alu_o != tail.expv);
        err_cnt  = err_q;
        fail_a   = fail_a_q;
        fail_b   = fail_b_q;
        fail_ctr = fail_ctr_q;
        fail_o   = fail_o_q;
        if (hit && err_q != 8'hFF) err_cnt = err_q + 8'd1;
        if (hit && !seen_q) begin
            fail_a   = tail.a;
            fail_b   = tail.b;
            fail_ctr = tail.ctr;
            fail_o   = alu_o;
        end
    end

    assign busy      = (state == S_RUN) || (state == S_DRAIN);
    assign done      = (state == S_DONE);
    assign pass      = done && (err_cnt == 8'h00);
    assign dbg_state = state;

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist: a behavioural ALU with selectable faults
// drives the DUT; a run-level model predicts error count and first failure.
module tb_alu_bist;
    localparam int          LAT  = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        ck = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] n_ops = 16'd0;
    logic [7:0]  a, b, alu_o, err_cnt, fail_a, fail_b, fail_o;
    logic [3:0]  ctr, fail_ctr;
    logic        busy, done, pass;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    int alu_mode = 0;
    logic [7:0] alu_r1;

    int m_errs, m_found, m_fa, m_fb, m_fc, m_fo;
    int m_la = 0, m_lb = 0, m_lc = 0;

    alu_bist #(.SEED(SEED), .LAT(LAT)) dut (
        .ck(ck), .rst(rst), .start(start), .n_ops(n_ops),
        .a(a), .b(b), .ctr(ctr), .alu_o(alu_o),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .fail_a(fail_a), .fail_b(fail_b), .fail_ctr(fail_ctr), .fail_o(fail_o),
        .dbg_state(dbg_state)
    );

    always #5 ck = ~ck;

    function automatic int golden(int x, int y, int op);
        case (op)
            0:       return (x + y) % 256;
            1:       return (x - y + 256) % 256;
            8:       return x & y;
            9:       return x | y;
            10:      return x ^ y;
            11:      return 255 - x;
            12:      return x / 2;
            13:      return (x * 2) % 256;
            14:      return x / 2 + (x % 2) * 128;
            15:      return (x * 2) % 256 + x / 128;
            default: return 0;
        endcase
    endfunction

    // 0 correct, 1 bit3 stuck-at-1, 2 FF on undefined ops, 3 inverted, 4 explicit 00 on undefined ops
    function automatic int alu_fn(int mode, int x, int y, int op);
        int g;
        g = golden(x, y, op);
        case (mode)
            1:       return g | 8;
            2:       return (op >= 2 && op <= 7) ? 255 : g;
            3:       return 255 - g;
            4:       return (op >= 2 && op <= 7) ? 0 : g;
            default: return g;
        endcase
    endfunction

    function automatic int m_step(int s);
        int fb;
        fb = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
        return (s >> 1) | (fb << 15);
    endfunction

    // Two-register ALU: result appears LAT=2 edges after the operands change.
    always @(posedge ck) begin
        alu_r1 <= 8'(alu_fn(alu_mode, int'(a), int'(b), int'(ctr)));
        alu_o  <= alu_r1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_run(input int mode, input int n);
        int s, va, vb, op, g, o, cnt;
        s = (SEED == 16'h0000) ? 1 : int'(SEED);
        cnt = 0;
        m_found = 0;
        m_fa = 0; m_fb = 0; m_fc = 0; m_fo = 0;
        for (int i = 0; i < n; i++) begin
            va = s % 256;
            vb = s / 256;
            op = (vb % 16) ^ (va % 16);
            g  = golden(va, vb, op);
            o  = alu_fn(mode, va, vb, op);
            if (o != g) begin
                if (m_found == 0) begin
                    m_found = 1;
                    m_fa = va; m_fb = vb; m_fc = op; m_fo = o;
                end
                cnt++;
            end
            m_la = va; m_lb = vb; m_lc = op;
            s = m_step(s);
        end
        m_errs = (cnt > 255) ? 255 : cnt;
    endtask

    task automatic run_check(input string tag, input int mode, input int n, input bit poke);
        int cyc, guard;
        alu_mode = mode;
        model_run(mode, n);
        @(negedge ck);
        start = 1'b1;
        n_ops = 16'(n);
        @(negedge ck);
        start = 1'b0;
        cyc = 0;
        guard = 0;
        while (!done && guard < 2000) begin
            if (busy) cyc++;
            if (poke && cyc == 5) begin
                start = 1'b1;
                n_ops = 16'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge ck);
            guard++;
        end
        start = 1'b0;
        chk({tag, "/done"}, 32'(done), 32'd1);
        chk({tag, "/busy_cycles"}, 32'(cyc), (n == 0) ? 32'd0 : 32'(n + LAT));
        if (n == 0) chk({tag, "/latency"}, 32'(guard), 32'd0);
        chk({tag, "/pass"}, 32'(pass), (m_errs == 0) ? 32'd1 : 32'd0);
        chk({tag, "/err_cnt"}, 32'(err_cnt), 32'(m_errs));
        if (m_found != 0) begin
            chk({tag, "/fail_a"}, 32'(fail_a), 32'(m_fa));
            chk({tag, "/fail_b"}, 32'(fail_b), 32'(m_fb));
            chk({tag, "/fail_ctr"}, 32'(fail_ctr), 32'(m_fc));
            chk({tag, "/fail_o"}, 32'(fail_o), 32'(m_fo));
        end
        chk({tag, "/hold_vec"}, {8'h0, a, b, 4'h0, ctr}, {8'h0, 8'(m_la), 8'(m_lb), 4'h0, 4'(m_lc)});
        repeat (2) @(negedge ck);
        chk({tag, "/done_hold"}, {30'd0, done, busy}, 32'd2);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "/vec"}, {12'h0, a, b, ctr}, 32'd0);
        chk({tag, "/flags"}, {29'd0, busy, done, pass}, 32'd0);
        chk({tag, "/err_cnt"}, 32'(err_cnt), 32'd0);
        chk({tag, "/fail"}, {4'h0, fail_a, fail_b, fail_ctr, fail_o}, 32'd0);
        chk({tag, "/state"}, 32'(dbg_state), 32'd0);
    endtask

    initial begin
        int n, mode;
        repeat (3) @(negedge ck);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge ck);
        chk("idle_after_reset", {30'd0, busy, done}, 32'd0);

        run_check("good_100", 0, 100, 1'b1);
        run_check("stuck3_50", 1, 50, 1'b0);
        run_check("undef_ff", 2, 64, 1'b0);
        chk("undef_ff/counted", (m_errs > 0) ? 32'd1 : 32'd0, 32'd1);
        run_check("undef_00", 4, 64, 1'b0);
        run_check("invert_300", 3, 300, 1'b0);
        run_check("nops_zero", 0, 0, 1'b0);

        for (int k = 0; k < 3; k++) begin
            n = $urandom_range(1, 40);
            mode = $urandom_range(0, 4);
            repeat ($urandom_range(0, 4)) @(negedge ck);
            run_check($sformatf("rand%0d", k), mode, n, 1'b0);
        end

        // Abort a failing run mid-flight; everything must clear at once.
        alu_mode = 1;
        @(negedge ck);
        start = 1'b1;
        n_ops = 16'd50;
        @(negedge ck);
        start = 1'b0;
        repeat (20) @(negedge ck);
        chk("midrun/busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk_all_zero("midrun_rst");
        m_la = 0; m_lb = 0; m_lc = 0;
        @(negedge ck);
        rst = 1'b0;
        run_check("after_rst_zero", 0, 0, 1'b0);
        run_check("after_rst_good", 0, 20, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_bist.md
ALU_BIST -- requirements
Module: alu_bist

Interface
REQ-001 SHALL have parameter SEED, default 16'hACE1, initial 16-bit LFSR value (0 replaced by 16'h0001).
REQ-002 SHALL have parameter LAT, default 2, rising edges from a/b/ctr change until alu_o holds the result.
REQ-003 SHALL have port ck  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  launch a test run (sampled in IDLE/DONE).
REQ-006 SHALL have port n_ops  input  16  number of vectors to issue, sampled with start.
REQ-007 SHALL have ports a, b  output  8 each  ALU operands, registered.
REQ-008 SHALL have port ctr  output  4  ALU opcode, registered.
REQ-009 SHALL have port alu_o  input  8  ALU result under test.
REQ-010 SHALL have ports busy, done, pass  output  1 each  run in progress / finished / finished with zero errors.
REQ-011 SHALL have port err_cnt  output  8  mismatch count, saturating.
REQ-012 SHALL have ports fail_a, fail_b  output  8 each and fail_ctr  output  4 and fail_o  output  8  first mismatching vector and observed result.

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> DRAIN -> DONE; start in IDLE or DONE -> RUN (or DONE directly if n_ops==0); start in RUN/DRAIN ignored.
REQ-014 SHALL on entering RUN clear err_cnt, fail_* and pass, load issue counter with n_ops, reload LFSR with SEED.
REQ-015 SHALL in RUN issue one vector per cycle: a=lfsr[7:0], b=lfsr[15:8], ctr=lfsr[11:8]^lfsr[3:0], then step LFSR (x^16+x^14+x^13+x^11+1, Fibonacci).
REQ-016 SHALL move RUN -> DRAIN in the cycle the n_ops-th vector is issued; DRAIN lasts LAT cycles, then DONE.
REQ-017 SHALL compute expected result per issued vector: 0000 a+b, 0001 a-b (mod 256), 1000 a&b, 1001 a|b, 1010 a^b, 1011 ~a, 1100 a>>1, 1101 a<<1, 1110 rotate-right-1, 1111 rotate-left-1, 0010..0111 8'h00.
REQ-018 SHALL carry expected value plus valid bit and issued vector through an LAT-deep pipeline; compare alu_o only when the aligned valid bit is 1.
REQ-019 SHALL on mismatch increment err_cnt, holding at 255.
REQ-020 SHALL capture fail_a/fail_b/fail_ctr/fail_o on the first mismatch of a run only.
REQ-021 SHALL hold a, b, ctr at last issued value outside RUN (8'h00/4'h0 after reset).
REQ-022 SHALL assert busy in RUN and DRAIN; done in DONE only; pass = done && err_cnt==0.
REQ-023 SHALL, when n_ops==0, enter DONE the cycle after start with pass=1, err_cnt=0.

Reset
REQ-024 SHALL on rst (any time, incl. mid-run) force IDLE, outputs all zero, LFSR=SEED, pipeline valid bits cleared.
REQ-025 SHALL resume normal operation on the first rising ck after rst deasserts.

Structure
REQ-026 SHALL place opcode constants, FSM state encoding and LFSR tap mask in package alu_bist_pkg.
REQ-027 SHALL instantiate one combinational sub-module alu_ref (a, b, ctr -> expected 8-bit) implementing REQ-017.

Verification
REQ-028 SHALL test: correct LAT=2 behavioural ALU, n_ops=100 -> done after 102 RUN/DRAIN cycles, pass=1, err_cnt=0.
REQ-029 SHALL test: ALU with alu_o[3] stuck-at-1, n_ops=50 -> pass=0, err_cnt equals model count, fail_* match first bad vector.
REQ-030 SHALL test: ALU returning 8'hFF for opcodes 0010..0111 -> each such vector counted; returning 8'h00 -> no error.
REQ-031 SHALL test: inverted-output ALU, n_ops=300 -> err_cnt=255 (saturated), pass=0.
REQ-032 SHALL test: n_ops=0 -> done=1, pass=1 one cycle after start; rst asserted mid-RUN -> IDLE, all outputs 0 immediately.
